// File: rtl/seg7_bcd2_scan.sv
// seg7_bcd2_scan: two-digit multiplexed seven-segment driver.
// Snapshots a BCD tens/units pair once per scan frame and time-multiplexes
// it onto a shared active-low segment bus with active-low anode enables,
// inserting an all-off gap after each digit to suppress ghosting.
// Optional blink feature: define SEG_BLINK_EN to add the blink port and a
// 6-bit frame counter that darkens every other group of 32 frames.
module seg7_bcd2_scan #(
  parameter int unsigned SCAN_DIV  = 50_000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q1,
  input  logic [3:0] q0,
`ifdef SEG_BLINK_EN
  input  logic       blink,
`endif
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned MAXLEN = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CW     = $clog2(MAXLEN);

  localparam logic [CW-1:0] DIG_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    DIG0   = 2'd0,
    BLANK0 = 2'd1,
    DIG1   = 2'd2,
    BLANK1 = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    snap_q, snap_d;   // {tens, units}
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          phase_last;
`ifdef SEG_BLINK_EN
  logic [5:0]    frame_q, frame_d;
`endif

  // BCD to active-high gfedcba; codes 10-15 show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Phase sequencing, snapshot capture and frame counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    snap_d  = snap_q;
`ifdef SEG_BLINK_EN
    frame_d = frame_q;
`endif
    if (state_q == DIG0 || state_q == DIG1) begin
      phase_last = (cnt_q == DIG_LAST);
    end else begin
      phase_last = (cnt_q == BLANK_LAST);
    end
    if (phase_last) begin
      cnt_d = '0;
      case (state_q)
        DIG0:    state_d = BLANK0;
        BLANK0:  state_d = DIG1;
        DIG1:    state_d = BLANK1;
        default: begin
          state_d = DIG0;
          snap_d  = {q1, q0};
`ifdef SEG_BLINK_EN
          frame_d = frame_q + 6'd1;
`endif
        end
      endcase
    end
  end

  // Display outputs: recomputed only on phase entry from the next state and
  // next snapshot, then held for the whole phase (so blink acts per DIG edge).
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (phase_last) begin
      an_d  = '1;
      seg_d = '1;
      case (state_d)
        DIG0: begin
          an_d  = 2'b10;
          seg_d = ~decode(snap_d[3:0]);
        end
        DIG1: begin
          if (snap_d[7:4] != 4'd0) begin
            an_d  = 2'b01;
            seg_d = ~decode(snap_d[7:4]);
          end
        end
        default: ;
      endcase
`ifdef SEG_BLINK_EN
      if (blink && frame_d[5]) begin
        an_d  = '1;
        seg_d = '1;
      end
`endif
    end
  end

  // State, counter, snapshot and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BLANK1;
      cnt_q   <= '0;
      snap_q  <= '0;
      an_q    <= '1;
      seg_q   <= '1;
`ifdef SEG_BLINK_EN
      frame_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
`ifdef SEG_BLINK_EN
      frame_q <= frame_d;
`endif
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_bcd2_scan.sv
// Directed bench for seg7_bcd2_scan with SCAN_DIV=8, BLANK_CYC=2.
// Expected {an,seg} values are queued per cycle as stimulus is set up and
// compared against the DUT one cycle at a time.
module tb_seg7_bcd2_scan;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;
  localparam logic [8:0]  OFF = {2'b11, 7'h7F};

  logic       clk;
  logic       reset;
  logic [3:0] q1;
  logic [3:0] q0;
  logic [6:0] seg;
  logic [1:0] an;
`ifdef SEG_BLINK_EN
  logic       blink;
`endif

  logic [8:0] sb[$];
  logic [8:0] exp_v;
  string      tag;
  int         checks;
  int         errors;

  seg7_bcd2_scan #(
    .SCAN_DIV (SD),
    .BLANK_CYC(BC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .q1   (q1),
    .q0   (q0),
`ifdef SEG_BLINK_EN
    .blink(blink),
`endif
    .seg  (seg),
    .an   (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_n(input logic [8:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) sb.push_back(v);
  endtask

  task automatic push_frame(input logic [1:0] an0, input logic [6:0] seg0,
                            input logic [1:0] an1, input logic [6:0] seg1);
    push_n({an0, seg0}, SD);
    push_n(OFF, BC);
    push_n({an1, seg1}, SD);
    push_n(OFF, BC);
  endtask

  // Advance n clocks, comparing #1 after each rising edge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checks++;
      assert (an !== 2'b00) else begin
        errors++;
        $error("FAIL %s anodes: observed an=%b required not 00", tag, an);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL %s queue: empty, observed %h", tag, {an, seg});
      end else begin
        exp_v = sb.pop_front();
        assert ({an, seg} === exp_v) else begin
          errors++;
          $error("FAIL %s: observed an=%b seg=%h required an=%b seg=%h",
                 tag, an, seg, exp_v[8:7], exp_v[6:0]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    q1     = 4'd0;
    q0     = 4'd0;
`ifdef SEG_BLINK_EN
    blink  = 1'b0;
`endif

    // Reset held three cycles: display dark.
    tag = "reset";
    push_n(OFF, 3);
    step(3);

    // Normal display 27; first DIG0 two cycles after release.
    tag = "normal";
    q1 = 4'd2;
    q0 = 4'd7;
    reset = 1'b1;
    push_n(OFF, 1);
    push_frame(2'b10, 7'h78, 2'b01, 7'h24);
    push_frame(2'b10, 7'h78, 2'b01, 7'h24);
    step(1 + 2 * (2 * (SD + BC)));

    // Leading-zero blanking on the tens digit.
    tag = "lzb";
    q1 = 4'd0;
    q0 = 4'd5;
    push_frame(2'b10, 7'h12, 2'b11, 7'h7F);
    step(2 * (SD + BC));

    // Mid-frame input change must not tear the current frame.
    tag = "tear";
    q1 = 4'd1;
    q0 = 4'd3;
    push_frame(2'b10, 7'h30, 2'b01, 7'h79);
    step(4);
    q0 = 4'd9;
    step(2 * (SD + BC) - 4);
    tag = "tear_next";
    push_frame(2'b10, 7'h10, 2'b01, 7'h79);
    step(2 * (SD + BC));

    // Invalid BCD shows a dash on both digits.
    tag = "invalid";
    q1 = 4'd12;
    q0 = 4'd15;
    push_frame(2'b10, 7'h3F, 2'b01, 7'h3F);
    step(2 * (SD + BC));

    // Reset mid-DIG0: off immediately, scan restarts from BLANK1.
    tag = "midreset";
    q1 = 4'd4;
    q0 = 4'd8;
    push_n({2'b10, 7'h00}, 3);
    step(3);
    reset = 1'b0;
    push_n(OFF, 2);
    step(2);
    reset = 1'b1;
    push_n(OFF, 1);
    push_frame(2'b10, 7'h00, 2'b01, 7'h19);
    step(1 + 2 * (SD + BC));

    tag = "drain";
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d leftover entries required 0", tag, sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
